fft8_output_serializer: RTL
===========================

// Module: fft8_output_serializer
// PURPOSE
//  Reader for the parallel FFT output frame. Captures one N-point complex frame
//  (all lanes in one cycle) from the FFT core into a two-slot ping-pong buffer.
//  Streams the frame out one complex sample per cycle over a valid/ready
//  interface, in natural or bit-reversed lane order.
//  Sits between the FFT core output and downstream serial consumers (e.g. a
//  magnitude unit or UART packer).
// PARAMETERS
//  WIDTH       16  bits per real/imag component
//  N           8   points per frame (power of 2)
//  LOG2N       3   log2(N); width of index fields
//  BIT_REVERSE 1   1: emit lanes in bit-reversed index order; 0: natural order
// PORTS
//  clk        in   1        clock, all state updates on rising edge
//  rst_n      in   1        asynchronous active-low reset
//  in_valid   in   1        frame present on in_re/in_im
//  in_ready   out  1        serializer can accept a frame this cycle
//  in_re      in   N*WIDTH  lane k at bits [k*WIDTH +: WIDTH]
//  in_im      in   N*WIDTH  same lane packing as in_re
//  out_valid  out  1        out_re/out_im/out_bin/out_last are valid
//  out_ready  in   1        downstream accepts the current sample
//  out_re     out  WIDTH    real part of the current sample
//  out_im     out  WIDTH    imaginary part of the current sample
//  out_bin    out  LOG2N    lane index of the current sample
//  out_last   out  1        current sample is the final one of its frame
// BEHAVIOUR
//  - Reset (rst_n=0, async): both slots=0, wr_ptr=rd_ptr=0, count=0, idx=0.
//    Outputs: out_valid=0, out_last=0, out_bin=0, out_re=out_im=0, in_ready=1.
//    Any buffered or partially emitted frame is discarded; no further output.
//  - State: count in {0,1,2} (full frames held), wr_ptr, rd_ptr (1 bit each),
//    idx (LOG2N bits, position within the frame being emitted).
//  - in_ready = (count != 2). Combinational from registered state only.
//    No same-cycle bypass of a slot being freed.
//  - Accept (in_valid & in_ready) at edge: all N lanes written to slot[wr_ptr];
//    wr_ptr toggles.
//  - out_valid = (count != 0). lane = BIT_REVERSE ? bitrev(idx) : idx.
//    Outputs: out_re/out_im = slot[rd_ptr][lane], out_bin = lane,
//    out_last = out_valid & (idx == N-1).
//  - Latency: a frame accepted at edge k gives out_valid=1 in the cycle after
//    edge k when count was 0. First sample is then visible after 1 clock.
//  - Handshake: a sample is consumed on out_valid & out_ready. idx increments.
//    When idx == N-1: idx wraps to 0, rd_ptr toggles, and the slot is freed.
//  - Stall: out_valid & !out_ready holds all out_* stable. A held slot is never
//    overwritten.
//  - count update per edge: accept & !release -> +1; release & !accept -> -1;
//    both or neither -> unchanged.
//  - Simultaneous accept and release with count=1 is legal. Back-to-back frames
//    stream with no bubble: the next cycle shows the first sample of the next
//    frame.
//  - in_valid while !in_ready: no state change. The upstream holds its frame.
//  - Arithmetic: pure data movement. No scaling, rounding or sign change; bits
//    are passed through exactly.
// TESTING
//  1 Reset: rst_n=0 with random inputs -> out_valid=0, out_re/im=0, in_ready=1.
//    Release -> same until the first frame.
//  2 BIT_REVERSE=0, in_re lane k = k, in_im lane k = 16'hFF00+k, out_ready=1
//    -> out_re = 0..7 on 8 consecutive cycles, out_last only on 7, then
//    out_valid=0.
//  3 BIT_REVERSE=1, same frame -> out_bin/out_re sequence 0,4,2,6,1,5,3,7.
//    out_last with value 7.
//  4 Backpressure: out_ready pattern 1,0,0,1,0,1... -> all 8 samples in order,
//    none duplicated or dropped. Outputs stable during every stall cycle.
//  5 Full/simultaneous: accept frames A,B with out_ready=0 -> in_ready=0, C
//    held. Drain A; on A's last-sample cycle in_valid=1 -> C not accepted that
//    edge. C accepted next edge. B streams without a bubble, then C.
//  6 Reset mid-stream: drop rst_n after 3 samples of A with B buffered ->
//    immediate out_valid=0. After release, only a newly supplied frame is
//    output.

Source files
------------

// File: rtl/fft8_output_serializer_if.sv
// Frame-in / sample-out handshake bundle for the FFT output serializer.
// The slave modport is the serializer's view; master is the surrounding logic.
interface fft8_output_serializer_if #(
  parameter int WIDTH = 16,
  parameter int N     = 8,
  parameter int LOG2N = 3
);
  logic               in_valid;
  logic               in_ready;
  logic [N*WIDTH-1:0] in_re;
  logic [N*WIDTH-1:0] in_im;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_re;
  logic [WIDTH-1:0]   out_im;
  logic [LOG2N-1:0]   out_bin;
  logic               out_last;

  modport slave (
    input  in_valid, in_re, in_im, out_ready,
    output in_ready, out_valid, out_re, out_im, out_bin, out_last
  );

  modport master (
    output in_valid, in_re, in_im, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_bin, out_last
  );
endinterface

// File: rtl/fft8_output_serializer.sv
// Captures a whole parallel FFT frame into a two-slot ping-pong buffer and
// streams it out one complex sample per cycle, natural or bit-reversed order.
module fft8_output_serializer #(
  parameter int WIDTH       = 16,
  parameter int N           = 8,
  parameter int LOG2N       = 3,
  parameter int BIT_REVERSE = 1
) (
  input logic                   clk,
  input logic                   rst_n,
  fft8_output_serializer_if.slave bus
);

  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    r = {LOG2N{1'b0}};
    for (int b = 0; b < LOG2N; b++) begin
      r[b] = v[LOG2N-1-b];
    end
    return r;
  endfunction

  logic [WIDTH-1:0] slot_re_r [2][N];
  logic [WIDTH-1:0] slot_im_r [2][N];
  logic [1:0]       count_r,  count_nxt_s;
  logic             wr_ptr_r, wr_ptr_nxt_s;
  logic             rd_ptr_r, rd_ptr_nxt_s;
  logic [LOG2N-1:0] idx_r,    idx_nxt_s;

  logic             in_ready_s;
  logic             out_valid_s;
  logic             accept_s;
  logic             consume_s;
  logic             release_s;
  logic [LOG2N-1:0] lane_s;

  // Handshake qualifiers, all derived from registered state only.
  always_comb begin
    in_ready_s  = (count_r != 2'd2);
    out_valid_s = (count_r != 2'd0);
    accept_s    = bus.in_valid & in_ready_s;
    consume_s   = out_valid_s & bus.out_ready;
    release_s   = consume_s & (idx_r == LAST_IDX);
    if (BIT_REVERSE != 0) begin
      lane_s = bitrev(idx_r);
    end else begin
      lane_s = idx_r;
    end
  end

  // Next-state for occupancy, pointers and emit position.
  always_comb begin
    count_nxt_s  = count_r;
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    idx_nxt_s    = idx_r;
    if (accept_s && !release_s) begin
      count_nxt_s = count_r + 2'd1;
    end else if (release_s && !accept_s) begin
      count_nxt_s = count_r - 2'd1;
    end else begin
      count_nxt_s = count_r;
    end
    if (accept_s) begin
      wr_ptr_nxt_s = ~wr_ptr_r;
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end
    if (release_s) begin
      idx_nxt_s    = {LOG2N{1'b0}};
      rd_ptr_nxt_s = ~rd_ptr_r;
    end else if (consume_s) begin
      idx_nxt_s    = idx_r + LOG2N'(1);
      rd_ptr_nxt_s = rd_ptr_r;
    end else begin
      idx_nxt_s    = idx_r;
      rd_ptr_nxt_s = rd_ptr_r;
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r  <= 2'd0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      idx_r    <= {LOG2N{1'b0}};
    end else begin
      count_r  <= count_nxt_s;
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      idx_r    <= idx_nxt_s;
    end
  end

  // Frame capture; the write slot is never the one being emitted while count != 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < 2; s++) begin
        for (int k = 0; k < N; k++) begin
          slot_re_r[s][k] <= {WIDTH{1'b0}};
          slot_im_r[s][k] <= {WIDTH{1'b0}};
        end
      end
    end else if (accept_s) begin
      for (int k = 0; k < N; k++) begin
        slot_re_r[wr_ptr_r][k] <= bus.in_re[k*WIDTH +: WIDTH];
        slot_im_r[wr_ptr_r][k] <= bus.in_im[k*WIDTH +: WIDTH];
      end
    end
  end

  // Output view of the current sample, forced to zero when nothing is held.
  always_comb begin
    bus.in_ready  = in_ready_s;
    bus.out_valid = out_valid_s;
    if (out_valid_s) begin
      bus.out_re   = slot_re_r[rd_ptr_r][lane_s];
      bus.out_im   = slot_im_r[rd_ptr_r][lane_s];
      bus.out_bin  = lane_s;
      bus.out_last = (idx_r == LAST_IDX);
    end else begin
      bus.out_re   = {WIDTH{1'b0}};
      bus.out_im   = {WIDTH{1'b0}};
      bus.out_bin  = {LOG2N{1'b0}};
      bus.out_last = 1'b0;
    end
  end

endmodule
